vdic_mult_pipe: RTL and testbench

//  Parametrised, pipelined parity-protected multiplier; successor of the 16x16 req/ack multiplier DUT.

---
 rtl/vdic_mult_pkg.sv | 22 ++
 rtl/vdic_sync_fifo.sv | 55 +++++
 rtl/vdic_mult_pipe.sv | 143 ++++++++++++++
 tb/tb_vdic_mult_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdic_mult_pkg.sv
// Shared types and helpers for the pipelined parity-protected multiplier.
//  - DEF_*       : default generics of vdic_mult_pipe
//  - mode_e      : per-transaction operand interpretation
//  - even_parity : XOR-reduction; narrower vectors are zero-extended by the caller
package vdic_mult_pkg;

  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_PIPE_STAGES = 3;
  localparam int unsigned DEF_FIFO_DEPTH  = 4;
  localparam int unsigned PAR_MAX_W       = 128;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mode_e;

  // Zero-extension leaves the XOR unchanged, so one fixed width serves every operand size.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/vdic_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers.
//  clk, rst      : clock, synchronous active-high reset (clears pointers)
//  push, wdata   : write request/data; ignored when full
//  pop           : read request; ignored when empty
//  rdata         : head entry, forced to 0 while empty
//  full, empty   : status
//  count         : current occupancy (0..DEPTH)
module vdic_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Equal indices: the wrap bit tells full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vdic_mult_pipe.sv
// Pipelined parity-protected multiplier with result FIFO and credit-based operand acceptance.
//  clk, rst                       : clock, synchronous active-high reset
//  arg_a/arg_b (+ _parity)        : operands with even parity bits
//  arg_signed                     : 1 = two's-complement, 0 = unsigned
//  req / ack                      : operand handshake; ack is combinational
//  result, result_parity          : FIFO head product and its parity
//  arg_parity_error               : FIFO head came from bad-parity operands
//  result_rdy / result_ack        : result handshake, pop on rdy & ack
module vdic_mult_pipe
  import vdic_mult_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned PIPE_STAGES = DEF_PIPE_STAGES,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   arg_a,
  input  logic                arg_a_parity,
  input  logic [DATA_W-1:0]   arg_b,
  input  logic                arg_b_parity,
  input  logic                arg_signed,
  input  logic                req,
  output logic                ack,
  output logic [2*DATA_W-1:0] result,
  output logic                result_parity,
  output logic                arg_parity_error,
  output logic                result_rdy,
  input  logic                result_ack
);

  localparam int unsigned RES_W = 2 * DATA_W;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [RES_W-1:0] prod;
    logic             par;
    logic             perr;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  mode_e                  mode;
  logic [RES_W-1:0]       ext_a;
  logic [RES_W-1:0]       ext_b;
  logic [RES_W-1:0]       prod_c;
  logic                   err_c;
  entry_t                 in_entry;
  entry_t                 stage_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] vld_q;
  logic [CNT_W-1:0]       inflight_q;
  logic [CNT_W-1:0]       fifo_count;
  logic [SUM_W-1:0]       outstanding;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   accept;
  logic                   pop;
  logic [ENTRY_W-1:0]     head_bits;
  entry_t                 head;

  // Operand extension, full-width product and parity check on the accepted operands
  always_comb begin
    in_entry = '0;
    mode     = mode_e'(arg_signed);
    if (mode == MODE_SIGNED) begin
      ext_a = {{DATA_W{arg_a[DATA_W-1]}}, arg_a};
      ext_b = {{DATA_W{arg_b[DATA_W-1]}}, arg_b};
    end else begin
      ext_a = {{DATA_W{1'b0}}, arg_a};
      ext_b = {{DATA_W{1'b0}}, arg_b};
    end
    // Truncating the 2W x 2W product to 2W is exact for sign-extended operands.
    prod_c = ext_a * ext_b;
    err_c  = (arg_a_parity != even_parity(PAR_MAX_W'(arg_a))) |
             (arg_b_parity != even_parity(PAR_MAX_W'(arg_b)));
    if (err_c) begin
      in_entry.perr = 1'b1;
    end else begin
      in_entry.prod = prod_c;
      in_entry.par  = even_parity(PAR_MAX_W'(prod_c));
    end
  end

  // Credits: in-pipeline work plus FIFO occupancy; a pop this cycle frees a slot
  assign pop         = ~fifo_empty & result_ack;
  assign outstanding = SUM_W'(inflight_q) + SUM_W'(fifo_count);
  assign ack         = req & ~rst & ((outstanding < SUM_W'(FIFO_DEPTH)) | pop);
  assign accept      = req & ack;
  assign fifo_push   = vld_q[PIPE_STAGES-1] & ~fifo_full;

  // Pipeline valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= accept;
      for (int unsigned i = 1; i < PIPE_STAGES; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Pipeline payload; meaningful only where the matching valid bit is set
  always_ff @(posedge clk) begin
    stage_q[0] <= in_entry;
    for (int unsigned i = 1; i < PIPE_STAGES; i++) stage_q[i] <= stage_q[i-1];
  end

  // Count of transactions still travelling down the pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
    end else begin
      case ({accept, fifo_push})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  vdic_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (stage_q[PIPE_STAGES-1]),
    .pop   (pop),
    .rdata (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head             = entry_t'(head_bits);
  assign result           = head.prod;
  assign result_parity    = head.par;
  assign arg_parity_error = head.perr;
  assign result_rdy       = ~fifo_empty;

endmodule

// File: tb/tb_vdic_mult_pipe.sv
// Bench for vdic_mult_pipe: a 16-bit instance for directed checks and an 8-bit instance
// for a randomised run with consumer stalls. Expected results are queued at acceptance
// and compared when the consumer pops.
module tb_vdic_mult_pipe;

  localparam int P = 3;

  typedef struct packed {
    logic [31:0] prod;
    logic        par;
    logic        perr;
  } exp_t;

  logic clk, rst;

  logic [15:0] a16, b16;
  logic        ap16, bp16, s16, req16, ack16, rp16, pe16, rdy16, rack16;
  logic [31:0] res16;

  logic [7:0]  a8, b8;
  logic        ap8, bp8, s8, req8, ack8, rp8, pe8, rdy8, rack8;
  logic [15:0] res8;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   pops16  = 0;
  int   pops8   = 0;
  exp_t q16[$];
  exp_t q8[$];

  vdic_mult_pipe #(.DATA_W(16), .PIPE_STAGES(P), .FIFO_DEPTH(4)) u_dut16 (
    .clk(clk), .rst(rst), .arg_a(a16), .arg_a_parity(ap16), .arg_b(b16), .arg_b_parity(bp16),
    .arg_signed(s16), .req(req16), .ack(ack16), .result(res16), .result_parity(rp16),
    .arg_parity_error(pe16), .result_rdy(rdy16), .result_ack(rack16)
  );

  vdic_mult_pipe #(.DATA_W(8), .PIPE_STAGES(P), .FIFO_DEPTH(4)) u_dut8 (
    .clk(clk), .rst(rst), .arg_a(a8), .arg_a_parity(ap8), .arg_b(b8), .arg_b_parity(bp8),
    .arg_signed(s8), .req(req8), .ack(ack8), .result(res8), .result_parity(rp8),
    .arg_parity_error(pe8), .result_rdy(rdy8), .result_ack(rack8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference product: explicit sign handling in 64-bit arithmetic, masked to 2*w bits
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic ap, input logic bp, input logic s);
    exp_t   e;
    longint sa, sb, p, mask;
    e = '0;
    if ((ap != ^a) || (bp != ^b)) begin
      e.perr = 1'b1;
      return e;
    end
    sa = longint'({48'h0, a});
    sb = longint'({48'h0, b});
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    p      = sa * sb;
    mask   = (longint'(1) << (2 * w)) - 1;
    e.prod = 32'(p & mask);
    e.par  = ^e.prod;
    return e;
  endfunction

  // Scoreboard: push on transfer, compare on pop (both observed mid-cycle)
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q16.delete();
      q8.delete();
    end else begin
      if (req16 && ack16) q16.push_back(model(16, a16, b16, ap16, bp16, s16));
      if (req8 && ack8)   q8.push_back(model(8, {8'h0, a8}, {8'h0, b8}, ap8, bp8, s8));
      if (rdy16 && rack16) begin
        pops16++;
        if (q16.size() == 0) check("sb16_unexpected", 64'd1, 64'd0);
        else begin
          e = q16.pop_front();
          check("sb16_result", res16, e.prod);
          check("sb16_parity", rp16, e.par);
          check("sb16_perr", pe16, e.perr);
        end
      end
      if (rdy8 && rack8) begin
        pops8++;
        if (q8.size() == 0) check("sb8_unexpected", 64'd1, 64'd0);
        else begin
          e = q8.pop_front();
          check("sb8_result", res8, e.prod);
          check("sb8_parity", rp8, e.par);
          check("sb8_perr", pe8, e.perr);
          check("sb8_par_consistent", rp8, ^res8);
        end
      end
    end
  end

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic s, input logic bad);
    logic got;
    a16 = a; b16 = b; ap16 = (^a) ^ bad; bp16 = ^b; s16 = s; req16 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = ack16;
      if (!got) begin
        @(posedge clk); #1;
      end
    end
    check("send16_ack", got, 1'b1);
    @(posedge clk); #1;
    req16 = 1'b0;
  endtask

  task automatic expect_head16(input string tag, input logic [31:0] r, input logic p, input logic e);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rdy16) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_rdy"}, got, 1'b1);
    check({tag, "_result"}, res16, r);
    check({tag, "_parity"}, rp16, p);
    check({tag, "_perr"}, pe16, e);
    @(posedge clk); #1 rack16 = 1'b1;
    @(posedge clk); #1 rack16 = 1'b0;
  endtask

  task automatic drain16();
    @(posedge clk); #1 rack16 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q16.size() == 0) break;
    end
    check("drain16_empty", 64'(q16.size()), 64'd0);
    @(posedge clk); #1 rack16 = 1'b0;
  endtask

  initial begin
    int   nack, nrdy, base;
    logic got;
    rst = 1'b1;
    {a16, b16, ap16, bp16, s16, req16, rack16} = '0;
    {a8, b8, ap8, bp8, s8, req8, rack8} = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state: ack held low even with req asserted
    req16 = 1'b1; a16 = 16'h0001; ap16 = 1'b1;
    @(negedge clk);
    check("rst_ack", ack16, 1'b0);
    check("rst_rdy", rdy16, 1'b0);
    check("rst_result", res16, 32'h0);
    check("rst_parity", rp16, 1'b0);
    check("rst_perr", pe16, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; req16 = 1'b0;

    // Signed 0x8000 * 0x8000 with exact latency
    send16(16'h8000, 16'h8000, 1'b1, 1'b0);
    for (int k = 1; k <= P + 1; k++) begin
      @(negedge clk);
      check($sformatf("lat_rdy_%0d", k), rdy16, (k == P + 1) ? 1'b1 : 1'b0);
    end
    expect_head16("t1", 32'h40000000, 1'b1, 1'b0);

    // Unsigned vs signed 0xFFFF * 0xFFFF
    send16(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    expect_head16("t2u", 32'hFFFE0001, 1'b0, 1'b0);
    send16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    expect_head16("t2s", 32'h00000001, 1'b1, 1'b0);

    // Wrong parity on arg_a
    send16(16'h0003, 16'h0002, 1'b0, 1'b1);
    expect_head16("t3", 32'h0, 1'b0, 1'b1);

    // Back-pressure: four credits, fifth waits for a pop
    base = pops16;
    for (int k = 0; k < 4; k++) send16(16'(k + 1), 16'(k + 10), 1'(k & 1), 1'b0);
    a16 = 16'hFFFB; b16 = 16'h0007; ap16 = ^a16; bp16 = ^b16; s16 = 1'b1; req16 = 1'b1;
    nack = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack16) nack++;
    end
    check("full_no_ack", 64'(nack), 64'd0);
    check("full_rdy", rdy16, 1'b1);
    @(posedge clk); #1 rack16 = 1'b1;
    @(negedge clk);
    check("ack_with_pop", ack16, 1'b1);
    @(posedge clk); #1;
    rack16 = 1'b0;
    a16 = 16'h1111; b16 = 16'h0100; ap16 = ^a16; bp16 = ^b16; s16 = 1'b0;
    @(negedge clk);
    check("ack_refull", ack16, 1'b0);
    @(posedge clk); #1 rack16 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ack16) begin
        got = 1'b1;
        break;
      end
    end
    check("sixth_ack", got, 1'b1);
    @(posedge clk); #1 req16 = 1'b0;
    drain16();
    check("t4_pops", 64'(pops16 - base), 64'd6);

    // Reset with one result in FIFO and two in flight
    send16(16'h0007, 16'h0009, 1'b0, 1'b0);
    repeat (P + 2) @(posedge clk);
    #1;
    send16(16'h0002, 16'h0003, 1'b1, 1'b0);
    send16(16'h0004, 16'h0005, 1'b0, 1'b0);
    rst = 1'b1; req16 = 1'b1; a16 = 16'h0001; ap16 = 1'b1;
    @(negedge clk);
    check("t5_ack_in_rst", ack16, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; req16 = 1'b0;
    @(negedge clk);
    check("t5_rdy", rdy16, 1'b0);
    check("t5_result", res16, 32'h0);
    check("t5_parity", rp16, 1'b0);
    check("t5_perr", pe16, 1'b0);
    check("t5_ack", ack16, 1'b0);
    nrdy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdy16) nrdy++;
    end
    check("t5_no_stale", 64'(nrdy), 64'd0);
    @(posedge clk); #1;
    send16(16'h1234, 16'h0010, 1'b0, 1'b0);
    expect_head16("t5_post", 32'h00012340, 1'b1, 1'b0);

    // Randomised 8-bit run with consumer stalls
    for (int n = 0; n < 1000; n++) begin
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      s8  = 1'($urandom);
      ap8 = (^a8) ^ ($urandom_range(0, 9) == 0);
      bp8 = (^b8) ^ ($urandom_range(0, 19) == 0);
      req8 = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
        @(negedge clk);
        got = ack8;
        @(posedge clk); #1;
        rack8 = ($urandom_range(0, 2) != 0);
      end
      req8 = 1'b0;
      if (!got) begin
        check("rand_ack_timeout", got, 1'b1);
        break;
      end
    end
    rack8 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q8.size() == 0) break;
    end
    check("rand_drain", 64'(q8.size()), 64'd0);
    check("rand_count", 64'(pops8), 64'd1000);
    @(posedge clk); #1 rack8 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
